// File: rtl/fir_frame_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_ctrl_pkg
//  Description : Shared types and constants for the FIR frame arbiter slice.
//                Holds the input FSM state type, the channel identifier type
//                and the number of requester channels.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    typedef logic chan_id_t;

    localparam int NUM_CH = 2;

endpackage
`default_nettype wire

// File: rtl/fir_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_frame_arbiter_if
//  Description : AXI-Stream bundle (tdata/tvalid/tlast/tready).
//                master : drives tdata/tvalid/tlast, receives tready
//                slave  : receives tdata/tvalid/tlast, drives tready
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_frame_arbiter_if #(
    parameter int AXI_BITWIDTH = 32
);
    logic [AXI_BITWIDTH-1:0] tdata;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/fir_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fir_id_fifo
//  Description : Synchronous FIFO of channel IDs, one entry per frame that is
//                granted into the FIR and not yet fully returned.
//  Ports       : clk, rstn (async active-low clear)
//                push/push_id : enqueue (ignored when full)
//                pop          : dequeue (ignored when empty)
//                full/empty/count/head : status and oldest entry
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_id_fifo
    import fir_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  chan_id_t               push_id,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output chan_id_t               head
);

    localparam int              c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth   = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0]   c_cnt_one = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

    chan_id_t        r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign full   = (r_count == c_depth);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];

    // Full only gates the push, so a pop always drains even at capacity.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Pointers are exactly log2(DEPTH) wide, so they wrap for free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fir_frame_arbiter
//  Description : Shares one FIR AXI-Stream engine between two requesters.
//                Grants whole frames (tlast-delimited) round-robin, records
//                the granted channel in an ID FIFO, and steers each FIR
//                output frame back to the channel at the FIFO head.
//  Ports       : clk, rstn (async active-low)
//                s0_axis, s1_axis : requester inputs (slave)
//                fir_s_axis       : to FIR input (master)
//                fir_m_axis       : from FIR output (slave)
//                m0_axis, m1_axis : filtered outputs (master)
//                inflight         : frames queued in the ID FIFO
//                err_orphan       : sticky, FIR output seen with no owner
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_frame_arbiter
    import fir_ctrl_pkg::*;
#(
    parameter int AXI_BITWIDTH  = 32,
    parameter int ID_FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    fir_frame_arbiter_if.slave             s0_axis,
    fir_frame_arbiter_if.slave             s1_axis,
    fir_frame_arbiter_if.master            fir_s_axis,
    fir_frame_arbiter_if.slave             fir_m_axis,
    fir_frame_arbiter_if.master            m0_axis,
    fir_frame_arbiter_if.master            m1_axis,
    output logic [$clog2(ID_FIFO_DEPTH):0] inflight,
    output logic                           err_orphan
);

    arb_state_t              r_state;
    arb_state_t              w_state_next;
    logic                    r_rr_last;
    logic                    r_err_orphan;
    logic                    w_grant0;
    logic                    w_grant1;
    logic                    w_push;
    chan_id_t                w_push_id;
    logic                    w_pop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    chan_id_t                w_head;
    logic [NUM_CH-1:0]       w_sink_ready;
    logic [AXI_BITWIDTH-1:0] w_fir_s_data;

    // Both grant terms are mutually exclusive: with both requesters valid,
    // the one opposite the last winner takes the frame.
    assign w_grant0 = ~w_fifo_full & s0_axis.tvalid & (~s1_axis.tvalid |  r_rr_last);
    assign w_grant1 = ~w_fifo_full & s1_axis.tvalid & (~s0_axis.tvalid | ~r_rr_last);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_rr_last    <= 1'b1;
            r_err_orphan <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_rr_last <= w_push_id;
            end
            if (w_fifo_empty && fir_m_axis.tvalid) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant0) begin
                    w_state_next = GRANT0;
                end else if (w_grant1) begin
                    w_state_next = GRANT1;
                end
            end
            GRANT0: begin
                if (s0_axis.tvalid && fir_s_axis.tready && s0_axis.tlast) begin
                    w_state_next = IDLE;
                end
            end
            GRANT1: begin
                if (s1_axis.tvalid && fir_s_axis.tready && s1_axis.tlast) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- output logic (input path + push) ----------------
    always_comb begin
        w_fir_s_data      = s0_axis.tdata;
        fir_s_axis.tvalid = 1'b0;
        fir_s_axis.tlast  = 1'b0;
        s0_axis.tready    = 1'b0;
        s1_axis.tready    = 1'b0;
        w_push            = 1'b0;
        w_push_id         = 1'b0;
        case (r_state)
            IDLE: begin
                w_push    = w_grant0 | w_grant1;
                w_push_id = w_grant1;
            end
            GRANT0: begin
                fir_s_axis.tvalid = s0_axis.tvalid;
                fir_s_axis.tlast  = s0_axis.tlast;
                s0_axis.tready    = fir_s_axis.tready;
            end
            GRANT1: begin
                w_fir_s_data      = s1_axis.tdata;
                fir_s_axis.tvalid = s1_axis.tvalid;
                fir_s_axis.tlast  = s1_axis.tlast;
                s1_axis.tready    = fir_s_axis.tready;
            end
            default: ;
        endcase
    end

    assign fir_s_axis.tdata = w_fir_s_data;

    // ---------------- output routing by FIFO head ----------------
    assign w_sink_ready      = {m1_axis.tready, m0_axis.tready};
    assign fir_m_axis.tready = ~w_fifo_empty & w_sink_ready[w_head];

    assign m0_axis.tdata  = fir_m_axis.tdata;
    assign m0_axis.tlast  = fir_m_axis.tlast;
    assign m0_axis.tvalid = ~w_fifo_empty & (w_head == 1'b0) & fir_m_axis.tvalid;
    assign m1_axis.tdata  = fir_m_axis.tdata;
    assign m1_axis.tlast  = fir_m_axis.tlast;
    assign m1_axis.tvalid = ~w_fifo_empty & (w_head == 1'b1) & fir_m_axis.tvalid;

    assign w_pop = fir_m_axis.tvalid & fir_m_axis.tready & fir_m_axis.tlast;

    fir_id_fifo #(
        .DEPTH (ID_FIFO_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (w_push),
        .push_id (w_push_id),
        .pop     (w_pop),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (inflight),
        .head    (w_head)
    );

    assign err_orphan = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_fir_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_frame_arbiter
//  Description : Bench for fir_frame_arbiter. Sources replay per-channel
//                frame queues, the FIR is a 3-cycle identity delay line, and
//                a monitor compares each sink beat with per-channel expected
//                queues filled when frames are issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_frame_arbiter;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int IW    = $clog2(DEPTH) + 1;

    typedef struct { logic [W-1:0] data; logic last; } beat_t;
    typedef struct { logic [W-1:0] data; logic last; int ch; int t; } fir_beat_t;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic [IW-1:0] inflight;
    logic          err_orphan;

    always #10 clk = ~clk;

    fir_frame_arbiter_if #(.AXI_BITWIDTH(W)) s0    ();
    fir_frame_arbiter_if #(.AXI_BITWIDTH(W)) s1    ();
    fir_frame_arbiter_if #(.AXI_BITWIDTH(W)) fir_s ();
    fir_frame_arbiter_if #(.AXI_BITWIDTH(W)) fir_m ();
    fir_frame_arbiter_if #(.AXI_BITWIDTH(W)) m0    ();
    fir_frame_arbiter_if #(.AXI_BITWIDTH(W)) m1    ();

    fir_frame_arbiter #(
        .AXI_BITWIDTH  (W),
        .ID_FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .s0_axis    (s0),
        .s1_axis    (s1),
        .fir_s_axis (fir_s),
        .fir_m_axis (fir_m),
        .m0_axis    (m0),
        .m1_axis    (m1),
        .inflight   (inflight),
        .err_orphan (err_orphan)
    );

    beat_t     src_q0[$], src_q1[$], exp_q0[$], exp_q1[$];
    fir_beat_t fir_q[$];
    int        dest_log[$];
    int        cyc = 0, src_cnt0 = 0, m_beats1 = 0, max_infl = 0;
    int        sink_mode0 = 0, sink_mode1 = 0;   // 0 ready, 1 stalled, 2 toggle, 3 random
    bit        fir_rand = 0, orphan = 0, s1_rdy_seen = 0, m1_val_seen = 0;
    int        checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic sink_val(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return cyc[0];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic push_frame(input int ch, input int len, input logic [W-1:0] base, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = rnd ? W'($urandom) : base + W'(i);
            b.last = (i == len - 1);
            if (ch == 0) begin src_q0.push_back(b); exp_q0.push_back(b); end
            else         begin src_q1.push_back(b); exp_q1.push_back(b); end
        end
    endtask

    task automatic clear_model();
        src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete(); fir_q.delete();
    endtask

    task automatic wait_drain(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1;
            done = (src_q0.size() == 0) && (src_q1.size() == 0) && (fir_q.size() == 0) &&
                   (exp_q0.size() == 0) && (exp_q1.size() == 0);
        end
        check("drain_done", done, 1);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rstn = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rstn = 1'b1;
    endtask

    // Drives sources, FIR delay line and sinks at the falling edge, then
    // books the handshakes that the next rising edge will complete.
    initial begin : engine
        fir_beat_t fb;
        logic      hs0, hs1;
        s0.tvalid = 0; s0.tlast = 0; s0.tdata = '0;
        s1.tvalid = 0; s1.tlast = 0; s1.tdata = '0;
        fir_m.tvalid = 0; fir_m.tlast = 0; fir_m.tdata = '0;
        fir_s.tready = 0; m0.tready = 0; m1.tready = 0;
        forever begin
            @(negedge clk);
            cyc++;
            s0.tvalid = (src_q0.size() > 0);
            if (s0.tvalid) begin s0.tdata = src_q0[0].data; s0.tlast = src_q0[0].last; end
            else s0.tlast = 0;
            s1.tvalid = (src_q1.size() > 0);
            if (s1.tvalid) begin s1.tdata = src_q1[0].data; s1.tlast = src_q1[0].last; end
            else s1.tlast = 0;
            fir_s.tready = fir_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (orphan) begin
                fir_m.tvalid = 1; fir_m.tdata = 32'hDEAD_BEEF; fir_m.tlast = 0;
            end else if (fir_q.size() > 0 && (cyc - fir_q[0].t) >= 3) begin
                fir_m.tvalid = 1; fir_m.tdata = fir_q[0].data; fir_m.tlast = fir_q[0].last;
            end else begin
                fir_m.tvalid = 0; fir_m.tlast = 0;
            end
            m0.tready = sink_val(sink_mode0);
            m1.tready = sink_val(sink_mode1);
            #4;
            if (rstn) begin
                hs0 = s0.tvalid & s0.tready;
                hs1 = s1.tvalid & s1.tready;
                if (fir_s.tvalid && fir_s.tready) begin
                    fb.data = fir_s.tdata; fb.last = fir_s.tlast; fb.ch = hs1 ? 1 : 0; fb.t = cyc;
                    fir_q.push_back(fb);
                end
                if (hs0) begin src_q0.delete(0); src_cnt0++; end
                if (hs1) src_q1.delete(0);
                if (fir_m.tvalid && fir_m.tready && !orphan && fir_q.size() > 0) fir_q.delete(0);
            end
        end
    end

    task automatic check_out(input int c, input logic [W-1:0] d, input logic l);
        beat_t b;
        bit    has_exp;
        has_exp = (c == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        check(c == 0 ? "m0_beat_expected" : "m1_beat_expected", has_exp, 1);
        if (has_exp) begin
            if (c == 0) begin b = exp_q0[0]; exp_q0.delete(0); end
            else        begin b = exp_q1[0]; exp_q1.delete(0); end
            check(c == 0 ? "m0_data" : "m1_data", d, b.data);
            check(c == 0 ? "m0_last" : "m1_last", l, b.last);
            if (l) dest_log.push_back(c);
            if (c == 1) m_beats1++;
        end
    endtask

    // Scoreboard monitor and per-cycle routing rules.
    initial begin : monitor
        int c;
        forever begin
            @(negedge clk); #3;
            if (rstn) begin
                if (m0.tvalid && m0.tready) check_out(0, m0.tdata, m0.tlast);
                if (m1.tvalid && m1.tready) check_out(1, m1.tdata, m1.tlast);
                if (fir_m.tvalid && !orphan && fir_q.size() > 0) begin
                    c = fir_q[0].ch;
                    if (c == 0) begin
                        check("route_m0_valid", m0.tvalid, 1);
                        check("route_m1_quiet", m1.tvalid, 0);
                        check("route_ready0", fir_m.tready, m0.tready);
                        check("route_data0", m0.tdata, fir_m.tdata);
                    end else begin
                        check("route_m1_valid", m1.tvalid, 1);
                        check("route_m0_quiet", m0.tvalid, 0);
                        check("route_ready1", fir_m.tready, m1.tready);
                        check("route_data1", m1.tdata, fir_m.tdata);
                    end
                end else if (!fir_m.tvalid) begin
                    check("m_idle_valid", {m0.tvalid, m1.tvalid}, 0);
                end
                check("single_src_ready", s0.tready & s1.tready, 0);
                if (fir_s.tvalid && fir_s.tready) begin
                    check("fir_in_one_src", (s0.tvalid & s0.tready) ^ (s1.tvalid & s1.tready), 1);
                    check("fir_in_data", fir_s.tdata, s1.tready ? s1.tdata : s0.tdata);
                end
                check("inflight_bound", inflight <= DEPTH, 1);
                if (int'(inflight) > max_infl) max_infl = int'(inflight);
                s1_rdy_seen |= s1.tready;
                m1_val_seen |= m1.tvalid;
            end
        end
    end

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit hit;
        // Reset state
        repeat (2) @(posedge clk); #1;
        check("rst_s_ready", {s0.tready, s1.tready}, 0);
        check("rst_fir_s_valid", fir_s.tvalid, 0);
        check("rst_fir_m_ready", fir_m.tready, 0);
        check("rst_m_valid", {m0.tvalid, m1.tvalid}, 0);
        check("rst_inflight", inflight, 0);
        check("rst_err_orphan", err_orphan, 0);
        @(negedge clk); #1;
        rstn = 1'b1;

        // Single channel frame
        s1_rdy_seen = 0; m1_val_seen = 0; max_infl = 0; dest_log.delete();
        push_frame(0, 4, 32'd1, 0);
        wait_drain(200);
        check("single_s1_ready_seen", s1_rdy_seen, 0);
        check("single_m1_valid_seen", m1_val_seen, 0);
        check("single_max_inflight", max_infl, 1);
        check("single_inflight_end", inflight, 0);
        check("single_frames", dest_log.size(), 1);

        // Contention from reset: grants must alternate starting with ch0
        do_reset();
        dest_log.delete();
        push_frame(0, 3, 32'h0000_0100, 0); push_frame(0, 3, 32'h0000_0200, 0);
        push_frame(1, 3, 32'h8000_1100, 0); push_frame(1, 3, 32'h8000_1200, 0);
        wait_drain(400);
        check("contend_frames", dest_log.size(), 4);
        if (dest_log.size() == 4)
            for (int i = 0; i < 4; i++) check("contend_order", dest_log[i], i % 2);

        // In-flight limit with output stalled
        sink_mode0 = 1; dest_log.delete();
        for (int i = 0; i < 5; i++) push_frame(0, 1, 32'hF000_0000 + 32'(i), 0);
        repeat (30) @(posedge clk); #1;
        check("limit_inflight", inflight, DEPTH);
        check("limit_s0_valid", s0.tvalid, 1);
        check("limit_s0_ready", s0.tready, 0);
        check("limit_pending", src_q0.size(), 1);
        sink_mode0 = 0;
        wait_drain(400);
        check("limit_frames", dest_log.size(), 5);
        check("limit_inflight_end", inflight, 0);

        // Backpressure toggle on channel 1 output
        sink_mode1 = 2; m_beats1 = 0;
        push_frame(1, 6, 32'h0, 1);
        wait_drain(400);
        check("bp_m1_beats", m_beats1, 6);
        sink_mode1 = 0;

        // Randomised traffic
        sink_mode0 = 3; sink_mode1 = 3; fir_rand = 1;
        for (int f = 0; f < 24; f++) push_frame(int'($urandom_range(0, 1)), int'($urandom_range(1, 5)), 32'h0, 1);
        wait_drain(5000);
        sink_mode0 = 0; sink_mode1 = 0; fir_rand = 0;
        @(posedge clk); #1;
        check("rand_inflight_end", inflight, 0);

        // Orphan FIR output
        orphan = 1;
        @(negedge clk); #2;
        check("orphan_fir_ready", fir_m.tready, 0);
        check("orphan_m_valid", {m0.tvalid, m1.tvalid}, 0);
        check("orphan_pre_edge", err_orphan, 0);
        @(posedge clk); #2;
        check("orphan_set", err_orphan, 1);
        orphan = 0;
        repeat (3) @(posedge clk); #2;
        check("orphan_sticky", err_orphan, 1);

        // Reset in the middle of a channel 0 frame
        src_cnt0 = 0;
        push_frame(0, 5, 32'h5500_0000, 0);
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk); #1;
            hit = (src_cnt0 >= 2);
        end
        check("midrst_reached_beat2", hit, 1);
        rstn = 1'b0;
        #1;
        check("midrst_s0_ready", s0.tready, 0);
        check("midrst_fir_s_valid", fir_s.tvalid, 0);
        check("midrst_fir_m_ready", fir_m.tready, 0);
        check("midrst_m_valid", {m0.tvalid, m1.tvalid}, 0);
        check("midrst_inflight", inflight, 0);
        check("midrst_err_orphan", err_orphan, 0);
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rstn = 1'b1;
        dest_log.delete();
        push_frame(1, 2, 32'h7700_0000, 0);
        push_frame(0, 2, 32'h6600_0000, 0);
        wait_drain(300);
        check("midrst_frames", dest_log.size(), 2);
        if (dest_log.size() > 0) check("midrst_first_grant", dest_log[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
